// File: rtl/countdown_sequencer_if.sv
// Control and display signals between the game-state controller and the
// pre-race countdown sequencer.
interface countdown_sequencer_if;
  logic       start;
  logic       pause;
  logic       abort;
  logic [1:0] num;
  logic       active;
  logic       digit_tick;
  logic       done;

  modport master (
    output start, pause, abort,
    input  num, active, digit_tick, done
  );

  modport slave (
    input  start, pause, abort,
    output num, active, digit_tick, done
  );
endinterface

// File: rtl/countdown_sequencer.sv
// 3-2-1 pre-race countdown: one digit per TICKS_PER_DIGIT cycles, freezes on
// pause, cancels on abort, and pulses done once on normal completion.
module countdown_sequencer #(
  parameter int unsigned TICKS_PER_DIGIT = 100_000_000,
  parameter int unsigned CNT_W           = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  countdown_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FROZEN, FIN} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_DIGIT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] presc, presc_nxt;
  logic [1:0]       num_r, num_nxt;
  logic             active_r, active_nxt;
  logic             tick_r, tick_nxt;
  logic             done_r, done_nxt;
  logic             expire;

  assign expire = (presc == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      presc    <= '0;
      num_r    <= 2'd0;
      active_r <= 1'b0;
      tick_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      num_r    <= num_nxt;
      active_r <= active_nxt;
      tick_r   <= tick_nxt;
      done_r   <= done_nxt;
    end
  end

  // FROZEN with pause released behaves exactly like RUN, so no cycle is lost.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) state_nxt = RUN;
      end
      RUN, FROZEN: begin
        if (bus.abort)                     state_nxt = IDLE;
        else if (bus.pause)                state_nxt = FROZEN;
        else if (expire && num_r == 2'd1)  state_nxt = FIN;
        else                               state_nxt = RUN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    presc_nxt  = presc;
    num_nxt    = num_r;
    active_nxt = active_r;
    tick_nxt   = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          presc_nxt  = '0;
          num_nxt    = 2'd3;
          active_nxt = 1'b1;
        end
      end
      RUN, FROZEN: begin
        if (bus.abort) begin
          presc_nxt  = '0;
          num_nxt    = 2'd0;
          active_nxt = 1'b0;
        end else if (!bus.pause) begin
          if (expire) begin
            presc_nxt = '0;
            tick_nxt  = 1'b1;
            if (num_r > 2'd1) begin
              num_nxt = num_r - 2'd1;
            end else begin
              num_nxt    = 2'd0;
              active_nxt = 1'b0;
              done_nxt   = 1'b1;
            end
          end else begin
            presc_nxt = presc + CNT_W'(1);
          end
        end
      end
      FIN: begin
        num_nxt    = 2'd0;
        active_nxt = 1'b0;
      end
      default: begin
        presc_nxt  = '0;
        num_nxt    = 2'd0;
        active_nxt = 1'b0;
      end
    endcase
  end

  assign bus.num        = num_r;
  assign bus.active     = active_r;
  assign bus.digit_tick = tick_r;
  assign bus.done       = done_r;

endmodule

// File: doc/countdown_sequencer.md
# countdown_sequencer

Generates the 3-2-1 pre-race countdown consumed by the on-screen number sprite. Receives a start pulse from the game-state controller when the game enters COUNTDOWN. Drives the 2-bit digit (3, 2, 1, then 0 for blank) with one full second per digit, and freezes while the game is paused. Issues a single-cycle `done` pulse that the game-state controller uses to advance to RACING.

## Interface
- `TICKS_PER_DIGIT`, default 100_000_000: clock cycles each digit is displayed (1 s at 100 MHz); minimum 2.
- `CNT_W`, default 27: prescaler width; must satisfy 2^CNT_W ≥ TICKS_PER_DIGIT.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion is synchronous to `clk` upstream.
- `start`  in  1  one-cycle request to begin the countdown.
- `pause`  in  1  level; while 1, countdown is frozen.
- `abort`  in  1  one-cycle request to cancel the countdown without completing.
- `num`  out  2  digit to draw: 3, 2, 1 while counting; 0 = draw nothing.
- `active`  out  1  high while the countdown is in progress (running or frozen).
- `digit_tick`  out  1  one-cycle pulse on every digit change and on completion (beeper hook).
- `done`  out  1  one-cycle pulse when the countdown completes normally.

## Operation
- States: IDLE, RUN, FROZEN, FIN.
- All outputs are registered. Reset values: `num`=0, `active`=0, `digit_tick`=0, `done`=0, prescaler=0, state IDLE.
- IDLE:
  - `start`=1 and `abort`=0 → RUN, `num`←3, prescaler←0, `active`←1.
  - `pause` is ignored in IDLE.
- RUN:
  - Each cycle the prescaler increments.
  - At prescaler = TICKS_PER_DIGIT−1, the prescaler clears and `digit_tick` pulses.
    - If `num` > 1: `num`←`num`−1.
    - If `num` = 1: → FIN.
- FIN (one cycle):
  - `done`=1, `num`=0, `active`=0.
  - Next cycle → IDLE.
  - A `start` during FIN is ignored.
- FROZEN:
  - Entered from RUN when `pause`=1.
  - Prescaler and `num` hold their values; `active` stays 1.
  - Returns to RUN on the first cycle `pause`=0, continuing from the held prescaler value. No restart, no lost ticks.
- Priority in RUN/FROZEN, per cycle: `abort` > `pause` > prescaler expiry > `start`.
  - `start` while RUN/FROZEN is ignored; it does not restart the count.
  - `abort`: → IDLE next edge, `num`←0, `active`←0, prescaler←0, no `done`, no `digit_tick`.
  - `pause`=1 on the expiry cycle: the expiry does not occur; the prescaler holds at TICKS_PER_DIGIT−1 and expires on the first unpaused cycle.
- Simultaneous `start`+`abort` in IDLE: remain IDLE.
- Asynchronous reset mid-count: outputs go to reset values immediately, with no `done` pulse.
- Arithmetic: the prescaler is unsigned CNT_W bits and never exceeds TICKS_PER_DIGIT−1. `num` never wraps below 1 while `active`.

## Timing
- `start` sampled high at edge E0 → `num`=3 and `active`=1 visible from E0.
- Without pauses:
  - `num`=3 for exactly T = TICKS_PER_DIGIT cycles.
  - Then `num`=2 for T cycles and `num`=1 for T cycles.
  - `done`=1 for exactly one cycle, starting 3T cycles after E0, coincident with `num`=0.
- `digit_tick` pulses at E0+T, E0+2T and E0+3T; the last one coincides with `done`.
- Each cycle with `pause`=1 while active delays every later event by exactly one cycle.
- Latency from `abort` to `num`=0: one edge.
- From `done`, a fresh `start` is accepted two cycles later (after FIN → IDLE).

## Test plan
All scenarios use TICKS_PER_DIGIT=4.
- **Reset:** hold `rst`=0, drive `start`=1 → `num`=0, `active`=0, `done`=0 throughout. Release `rst` → still IDLE until `start`.
- **Nominal:** `start` pulse at cycle 0.
  - `num` = 3 for cycles 1–4, 2 for cycles 5–8, 1 for cycles 9–12.
  - `done`=1 and `num`=0 only at cycle 13.
  - `digit_tick` at cycles 5, 9 and 13.
- **Pause:** nominal start, then `pause`=1 for cycles 6–8 (3 cycles) → `num`=2 held; `num`=1 appears at cycle 12; `done` at cycle 16.
- **Pause at expiry:** `pause`=1 exactly on the cycle where `num` would change 3→2 → the change is deferred until the cycle after `pause` falls; `num` never skips a digit.
- **Abort:** `abort` at cycle 7 (num=2) → `num`=0 and `active`=0 from cycle 8; no `done` ever. A new `start` at cycle 10 yields `num`=3 at cycle 11.
- **Ignored requests:**
  - `start` re-pulsed at cycle 3 → no restart; `done` still at cycle 13.
  - `start`+`abort` together in IDLE → nothing happens.
  - `start` during the FIN cycle → ignored.
